// File: rtl/correlator_scheduler.sv
// Correlator control: UART command decode, integration frame pacing with
// snapshot/counter_reset strobes, and the frame handoff to the UART serializer.
module correlator_scheduler #(
    parameter int NUM_INPUTS     = 4,
    parameter int DELAY_WIDTH    = 20,
    parameter int PERIOD_WIDTH   = 32,
    parameter int DEFAULT_PERIOD = 50000000,
    parameter int MIN_PERIOD     = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    input  logic                              tx_busy,
    output logic                              tx_start,
    output logic                              snapshot,
    output logic                              counter_reset,
    output logic [NUM_INPUTS*DELAY_WIDTH-1:0] delay,
    output logic [31:0]                       leds,
    output logic [3:0]                        baud_rate,
    output logic                              transmit_enable,
    output logic [7:0]                        dropped_frames
);
    localparam logic [3:0] OP_CLEAR      = 4'd0;
    localparam logic [3:0] OP_SET_INDEX  = 4'd1;
    localparam logic [3:0] OP_SET_LEDS   = 4'd2;
    localparam logic [3:0] OP_SET_BAUD   = 4'd3;
    localparam logic [3:0] OP_SET_DELAY  = 4'd4;
    localparam logic [3:0] OP_COMMIT     = 4'd5;
    localparam logic [3:0] OP_SET_PERIOD = 4'd6;
    localparam logic [3:0] OP_ENABLE     = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE
    } tx_state_t;

    tx_state_t               state_reg, state_next;
    logic [3:0]              index_reg;
    logic [2:0]              ptr_reg;
    logic                    commit_pending_reg;
    logic [31:0]             leds_reg;
    logic [3:0]              baud_rate_reg;
    logic                    transmit_enable_reg;
    logic [7:0]              dropped_reg;
    logic [PERIOD_WIDTH-1:0] period_reg, shadow_period_reg, cnt_reg;
    logic                    snapshot_reg, counter_reset_reg;
    logic                    drop;

    logic [3:0] opcode, arg;
    logic       cmd_clear, cmd_set_index, cmd_set_leds, cmd_set_baud;
    logic       cmd_set_delay, cmd_commit, cmd_set_period, cmd_enable;
    logic       apply;

    assign opcode         = rx_data[3:0];
    assign arg            = rx_data[7:4];
    assign cmd_clear      = rx_valid && (opcode == OP_CLEAR);
    assign cmd_set_index  = rx_valid && (opcode == OP_SET_INDEX);
    assign cmd_set_leds   = rx_valid && (opcode == OP_SET_LEDS);
    assign cmd_set_baud   = rx_valid && (opcode == OP_SET_BAUD);
    assign cmd_set_delay  = rx_valid && (opcode == OP_SET_DELAY) && (int'(index_reg) < NUM_INPUTS);
    assign cmd_commit     = rx_valid && (opcode == OP_COMMIT);
    assign cmd_set_period = rx_valid && (opcode == OP_SET_PERIOD);
    assign cmd_enable     = rx_valid && (opcode == OP_ENABLE);

    // Shadow copies move to the active set only on a snapshot cycle.
    assign apply = snapshot_reg && commit_pending_reg;

    // Nibble write masks; nibbles past the register width select nothing.
    logic [DELAY_WIDTH-1:0]  delay_mask, delay_data;
    logic [PERIOD_WIDTH-1:0] period_mask, period_data;

    always_comb begin
        delay_mask  = '0;
        delay_data  = '0;
        period_mask = '0;
        period_data = '0;
        for (int b = 0; b < DELAY_WIDTH; b++) begin
            delay_mask[b] = ((b / 4) == int'(ptr_reg));
            delay_data[b] = arg[b % 4];
        end
        for (int b = 0; b < PERIOD_WIDTH; b++) begin
            period_mask[b] = ((b / 4) == int'(ptr_reg));
            period_data[b] = arg[b % 4];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
            logic [DELAY_WIDTH-1:0] shadow_delay_reg, active_delay_reg;
            logic                   lane_wr;

            assign lane_wr = cmd_set_delay && (int'(index_reg) == gi);

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    shadow_delay_reg <= '0;
                    active_delay_reg <= '0;
                end else begin
                    if (lane_wr)
                        shadow_delay_reg <= (shadow_delay_reg & ~delay_mask) | (delay_data & delay_mask);
                    if (apply)
                        active_delay_reg <= shadow_delay_reg;
                end
            end

            assign delay[gi*DELAY_WIDTH +: DELAY_WIDTH] = active_delay_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index_reg           <= '0;
            ptr_reg             <= '0;
            commit_pending_reg  <= 1'b0;
            leds_reg            <= '0;
            baud_rate_reg       <= '0;
            transmit_enable_reg <= 1'b0;
            dropped_reg         <= '0;
            shadow_period_reg   <= PERIOD_WIDTH'(DEFAULT_PERIOD);
            period_reg          <= PERIOD_WIDTH'(DEFAULT_PERIOD);
        end else begin
            if (cmd_set_index)
                index_reg <= arg;
            if (cmd_set_leds)
                leds_reg[index_reg*2 +: 2] <= arg[1:0];
            if (cmd_set_baud)
                baud_rate_reg <= arg;
            if (cmd_enable)
                transmit_enable_reg <= arg[0];

            if (cmd_clear)
                ptr_reg <= '0;
            else if (cmd_set_delay || cmd_set_period)
                ptr_reg <= ptr_reg + 3'd1;

            // A COMMIT landing on the applying snapshot re-arms for the next one.
            if (cmd_commit)
                commit_pending_reg <= 1'b1;
            else if (apply)
                commit_pending_reg <= 1'b0;

            if (cmd_set_period)
                shadow_period_reg <= (shadow_period_reg & ~period_mask) | (period_data & period_mask);
            if (apply)
                period_reg <= (shadow_period_reg < PERIOD_WIDTH'(MIN_PERIOD)) ?
                              PERIOD_WIDTH'(MIN_PERIOD) : shadow_period_reg;

            if (cmd_clear)
                dropped_reg <= '0;
            else if (drop && (dropped_reg != 8'hFF))
                dropped_reg <= dropped_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg           <= '0;
            snapshot_reg      <= 1'b0;
            counter_reset_reg <= 1'b0;
        end else begin
            counter_reset_reg <= snapshot_reg;
            if (cnt_reg >= period_reg - PERIOD_WIDTH'(1)) begin
                cnt_reg      <= '0;
                snapshot_reg <= 1'b1;
            end else begin
                cnt_reg      <= cnt_reg + PERIOD_WIDTH'(1);
                snapshot_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        tx_start   = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (snapshot_reg && transmit_enable_reg) begin
                    if (!tx_busy)
                        state_next = ST_START;
                    else
                        drop = 1'b1;
                end
            end
            ST_START: begin
                tx_start = 1'b1;
                drop     = snapshot_reg;
                if (tx_busy)
                    state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                drop = snapshot_reg;
                if (!tx_busy)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign snapshot        = snapshot_reg;
    assign counter_reset   = counter_reset_reg;
    assign leds            = leds_reg;
    assign baud_rate       = baud_rate_reg;
    assign transmit_enable = transmit_enable_reg;
    assign dropped_frames  = dropped_reg;

endmodule

// File: tb/tb_correlator_scheduler.sv
// Directed bench for correlator_scheduler: expected values are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_correlator_scheduler;
    localparam int NI = 4;
    localparam int DW = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_busy;
    logic              tx_start;
    logic              snapshot;
    logic              counter_reset;
    logic [NI*DW-1:0]  delay;
    logic [31:0]       leds;
    logic [3:0]        baud_rate;
    logic              transmit_enable;
    logic [7:0]        dropped_frames;

    correlator_scheduler #(
        .NUM_INPUTS     (NI),
        .DELAY_WIDTH    (DW),
        .PERIOD_WIDTH   (32),
        .DEFAULT_PERIOD (10),
        .MIN_PERIOD     (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .snapshot        (snapshot),
        .counter_reset   (counter_reset),
        .delay           (delay),
        .leds            (leds),
        .baud_rate       (baud_rate),
        .transmit_enable (transmit_enable),
        .dropped_frames  (dropped_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [79:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       edge_no = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic tick_until(input int target);
        while (edge_no < target) tick();
    endtask

    task automatic expect_v(input string tag, input logic [79:0] v);
        sb_item_t it;
        it.tag = $sformatf("%s@%0d", tag, edge_no);
        it.exp = v;
        sb_q.push_back(it);
    endtask

    task automatic check(input logic [79:0] obs);
        sb_item_t it;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
            return;
        end
        it = sb_q.pop_front();
        assert (obs === it.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", it.tag, obs, it.exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_reset_values();
        expect_v("rst_tx_start", 80'(0));        check(80'(tx_start));
        expect_v("rst_snapshot", 80'(0));        check(80'(snapshot));
        expect_v("rst_counter_reset", 80'(0));   check(80'(counter_reset));
        expect_v("rst_delay", 80'(0));           check(80'(delay));
        expect_v("rst_leds", 80'(0));            check(80'(leds));
        expect_v("rst_baud", 80'(0));            check(80'(baud_rate));
        expect_v("rst_enable", 80'(0));          check(80'(transmit_enable));
        expect_v("rst_dropped", 80'(0));         check(80'(dropped_frames));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [79:0] lane2_exp;
        logic        snap_e, cr_e;
        lane2_exp = 80'h00135 << 40;

        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) tick();
        check_reset_values();
        reset_n = 1'b1;
        edge_no = 0;

        // Idle framing with period 10, capture disabled.
        for (int e = 1; e <= 31; e++) begin
            snap_e = (e % 10 == 0);
            cr_e   = (e % 10 == 1) && (e != 1);
            expect_v("snap_cr_tx", 80'({snap_e, cr_e, 1'b0}));
            tick();
            check(80'({snapshot, counter_reset, tx_start}));
        end

        // Delay nibbles for input 2, committed at the next snapshot.
        send_byte(8'h21); send_byte(8'h00); send_byte(8'h54);
        send_byte(8'h34); send_byte(8'h14); send_byte(8'h05);
        expect_v("delay_before_commit", 80'(0)); check(80'(delay));
        tick_until(40);
        expect_v("snap_at_40", 80'(1));          check(80'(snapshot));
        expect_v("delay_on_snap", 80'(0));       check(80'(delay));
        tick();
        expect_v("delay_committed", lane2_exp);  check(80'(delay));
        expect_v("cr_at_41", 80'(1));            check(80'(counter_reset));

        // Capture handshake with a serializer busy for three cycles.
        send_byte(8'h1D);
        expect_v("enable_on", 80'(1));           check(80'(transmit_enable));
        tick_until(50);
        expect_v("snap_tx_at_50", 80'(2'b10));   check(80'({snapshot, tx_start}));
        tick();
        expect_v("tx_start_rise", 80'(1));       check(80'(tx_start));
        tick();
        expect_v("tx_start_held", 80'(1));       check(80'(tx_start));
        tx_busy = 1'b1;
        tick();
        expect_v("tx_start_drop", 80'(0));       check(80'(tx_start));
        tick(); tick();
        tx_busy = 1'b0;
        tick();
        tick_until(60);
        expect_v("snap_at_60", 80'(1));          check(80'(snapshot));
        tick();
        expect_v("tx_start_frame2", 80'(1));     check(80'(tx_start));
        expect_v("no_drops", 80'(0));            check(80'(dropped_frames));
        tx_busy = 1'b1;
        tick();
        expect_v("tx_start_drop2", 80'(0));      check(80'(tx_start));
        tick();
        tx_busy = 1'b0;
        tick();
        send_byte(8'h0D);
        expect_v("enable_off", 80'(0));          check(80'(transmit_enable));

        // Period 2 clamps to 4; COMMIT lands on a snapshot cycle so it waits a frame.
        tick_until(71);
        send_byte(8'h00);
        send_byte(8'h26);
        repeat (7) send_byte(8'h06);
        tick_until(80);
        send_byte(8'h05);
        for (int e = 82; e <= 102; e++) begin
            snap_e = (e >= 90) && ((e - 90) % 4 == 0);
            cr_e   = (e >= 91) && ((e - 91) % 4 == 0);
            expect_v("clamp_snap_cr_tx", 80'({snap_e, cr_e, 1'b0}));
            tick();
            check(80'({snapshot, counter_reset, tx_start}));
        end

        // Serializer stuck busy: drop counting and saturation.
        send_byte(8'h1D);
        tick_until(106);
        expect_v("snap_at_106", 80'(1));         check(80'(snapshot));
        tick();
        expect_v("tx_start_107", 80'(1));        check(80'(tx_start));
        tx_busy = 1'b1;
        tick();
        expect_v("wait_done_108", 80'(0));       check(80'(tx_start));
        tick_until(111);
        expect_v("drop_1", 80'(1));              check(80'(dropped_frames));
        tick();
        expect_v("drop_1_held", 80'(1));         check(80'(dropped_frames));
        tick_until(115);
        expect_v("drop_2", 80'(2));              check(80'(dropped_frames));
        tick_until(1123);
        expect_v("drop_254", 80'(254));          check(80'(dropped_frames));
        tick_until(1127);
        expect_v("drop_255", 80'(255));          check(80'(dropped_frames));
        tick_until(1140);
        expect_v("drop_saturated", 80'(255));    check(80'(dropped_frames));
        tick_until(1142);
        send_byte(8'h00);
        expect_v("clear_beats_drop", 80'(0));    check(80'(dropped_frames));
        tick_until(1147);
        expect_v("drop_after_clear", 80'(1));    check(80'(dropped_frames));

        // All LEDs on and a baud select, then reset while in WAIT_DONE.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'((i << 4) | 1));
            send_byte(8'h32);
        end
        expect_v("leds_all_on", 80'(32'hFFFF_FFFF)); check(80'(leds));
        send_byte(8'hA3);
        expect_v("baud_a", 80'(4'hA));           check(80'(baud_rate));
        reset_n = 1'b0;
        tick();
        check_reset_values();
        reset_n = 1'b1;
        tx_busy = 1'b0;
        edge_no = 0;

        // FSM back in IDLE and period back to default after reset.
        send_byte(8'h1D);
        tick_until(10);
        expect_v("post_rst_snap_tx", 80'(2'b10)); check(80'({snapshot, tx_start}));
        tick();
        expect_v("post_rst_tx_start", 80'(1));   check(80'(tx_start));
        expect_v("post_rst_delay", 80'(0));      check(80'(delay));
        expect_v("post_rst_leds", 80'(0));       check(80'(leds));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
